// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and the line/frame geometry derived from them.
package vga_timing_pkg;
   typedef logic [9:0] pos_t;
   function automatic int axis_total(int d, int f, int s, int b);
      return d + f + s + b;
   endfunction
   localparam int H_DISPLAY_D    = 640;
   localparam int H_FRONT_D      = 16;
   localparam int H_SYNC_D       = 96;
   localparam int H_BACK_D       = 48;
   localparam int V_DISPLAY_D    = 480;
   localparam int V_FRONT_D      = 10;
   localparam int V_SYNC_D       = 2;
   localparam int V_BACK_D       = 33;
   localparam int H_TOTAL_D      = axis_total(H_DISPLAY_D, H_FRONT_D, H_SYNC_D, H_BACK_D);
   localparam int V_TOTAL_D      = axis_total(V_DISPLAY_D, V_FRONT_D, V_SYNC_D, V_BACK_D);
   localparam int H_SYNC_START_D = H_DISPLAY_D + H_FRONT_D;
   localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
   localparam int V_SYNC_START_D = V_DISPLAY_D + V_FRONT_D;
   localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis -- wrapping position counter, wrap flag, registered sync
// and next-state visible decode so decodes line up with the position register.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int DISPLAY = H_DISPLAY_D,
   parameter int FRONT   = H_FRONT_D,
   parameter int SYNC    = H_SYNC_D,
   parameter int BACK    = H_BACK_D
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output pos_t o_pos,
   output logic o_wrap,
   output logic o_sync,
   output logic o_vis_next
);
   localparam pos_t L_LAST = pos_t'(axis_total(DISPLAY, FRONT, SYNC, BACK) - 1);
   localparam pos_t L_DISP = pos_t'(DISPLAY);
   localparam pos_t L_SS   = pos_t'(DISPLAY + FRONT);
   localparam pos_t L_SE   = pos_t'(DISPLAY + FRONT + SYNC);
   pos_t r_pos, w_pos_next;
   logic r_sync;
   always_comb begin
      o_wrap     = i_en && (r_pos == L_LAST);
      w_pos_next = o_wrap ? '0 : r_pos + pos_t'(i_en);
      o_vis_next = w_pos_next < L_DISP;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos  <= '0;
         r_sync <= 1'b1;
      end else begin
         r_pos  <= w_pos_next;
         r_sync <= !(w_pos_next >= L_SS && w_pos_next < L_SE);
      end
   end
   assign o_pos  = r_pos;
   assign o_sync = r_sync;
endmodule

// File: rtl/vga_timing_core.sv
// vga_timing_core: VGA raster timing generator; the vertical axis steps on the horizontal wrap.
module vga_timing_core
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = H_DISPLAY_D,
   parameter int H_FRONT   = H_FRONT_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BACK    = H_BACK_D,
   parameter int V_DISPLAY = V_DISPLAY_D,
   parameter int V_FRONT   = V_FRONT_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BACK    = V_BACK_D
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       line_start,
   output logic       frame_start,
   output logic [9:0] frame_count
);
   logic w_h_wrap, w_v_wrap, w_h_vis, w_v_vis;
   logic r_display_on, r_line_start, r_frame_start;
   pos_t r_frame_count;
   vga_axis_counter #(.DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
      .clk(clk), .rst_n(rst_n), .i_en(en),
      .o_pos(hpos), .o_wrap(w_h_wrap), .o_sync(hsync), .o_vis_next(w_h_vis)
   );
   vga_axis_counter #(.DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
      .clk(clk), .rst_n(rst_n), .i_en(w_h_wrap),
      .o_pos(vpos), .o_wrap(w_v_wrap), .o_sync(vsync), .o_vis_next(w_v_vis)
   );
   // vertical wrap is only possible on a horizontal wrap, so it marks the frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_display_on  <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_display_on  <= w_h_vis && w_v_vis;
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_v_wrap;
         r_frame_count <= r_frame_count + pos_t'(w_v_wrap);
      end
   end
   assign display_on  = r_display_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_count = r_frame_count;
endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed checks on a default-timing instance and a tiny 7x5 instance
// (hsync low at h=5, vsync low at v=3, visible h<4 && v<2) used for frame-scale behaviour.
module tb_vga_timing_core;
   logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
   logic hsync, vsync, display_on, line_start, frame_start;
   logic [9:0] hpos, vpos, frame_count;
   logic s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
   logic [9:0] s_hpos, s_vpos, s_frame_count;
   int n_cmp = 0, n_err = 0;

   vga_timing_core dut (
      .clk(clk), .rst_n(rst_n), .en(en), .hsync(hsync), .vsync(vsync), .display_on(display_on),
      .hpos(hpos), .vpos(vpos), .line_start(line_start), .frame_start(frame_start),
      .frame_count(frame_count)
   );
   vga_timing_core #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                     .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) sml (
      .clk(clk), .rst_n(rst_n), .en(en), .hsync(s_hsync), .vsync(s_vsync), .display_on(s_display_on),
      .hpos(s_hpos), .vpos(s_vpos), .line_start(s_line_start), .frame_start(s_frame_start),
      .frame_count(s_frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".hpos"}, hpos, 0);
      chk({tag, ".vpos"}, vpos, 0);
      chk({tag, ".fc"}, frame_count, 0);
      chk({tag, ".hsync"}, hsync, 1);
      chk({tag, ".vsync"}, vsync, 1);
      chk({tag, ".disp"}, display_on, 1);
      chk({tag, ".ls"}, line_start, 0);
      chk({tag, ".fs"}, frame_start, 0);
   endtask

   initial begin
      int e, h, v;
      #1 rst_n = 1'b0;
      #1 chk_reset("rst_async");
      step(2);
      rst_n = 1'b1;
      en = 1'b1;
      chk_reset("rst_release");
      step(1);
      chk("first_clk.hpos", hpos, 1);
      chk("first_clk.ls", line_start, 0);
      chk("first_clk.fs", frame_start, 0);
      chk("first_clk.s_hpos", s_hpos, 1);
      step(638);
      chk("h639.disp", display_on, 1);
      chk("h639.hsync", hsync, 1);
      step(1);
      chk("h640.hpos", hpos, 640);
      chk("h640.disp", display_on, 0);
      step(15);
      chk("h655.hsync", hsync, 1);
      step(1);
      chk("h656.hsync", hsync, 0);
      step(95);
      chk("h751.hpos", hpos, 751);
      chk("h751.hsync", hsync, 0);
      step(1);
      chk("h752.hsync", hsync, 1);
      step(47);
      chk("h799.hpos", hpos, 799);
      chk("h799.vpos", vpos, 0);
      chk("h799.ls", line_start, 0);
      step(1);
      chk("line1.hpos", hpos, 0);
      chk("line1.vpos", vpos, 1);
      chk("line1.ls", line_start, 1);
      chk("line1.fs", frame_start, 0);
      chk("line1.disp", display_on, 1);
      step(1);
      chk("line1_next.ls", line_start, 0);
      step(7998);
      chk("v10.hpos", hpos, 799);
      chk("v10.vpos", vpos, 10);
      step(1);
      chk("v11.hpos", hpos, 0);
      chk("v11.vpos", vpos, 11);
      chk("v11.ls", line_start, 1);
      chk("v11.fs", frame_start, 0);
      chk("v11.vsync", vsync, 1);
      // 8800 en-cycles on the 35-cycle small frame: 251 frames, then 15 -> (1, 2)
      chk("sml8800.fc", s_frame_count, 251);
      chk("sml8800.hpos", s_hpos, 1);
      chk("sml8800.vpos", s_vpos, 2);
      step(6);
      chk("sml_v3.vpos", s_vpos, 3);
      chk("sml_v3.vsync", s_vsync, 0);
      chk("dut8806.hpos", hpos, 6);
      #2 rst_n = 1'b0;
      #1;
      chk("async.s_vsync", s_vsync, 1);
      chk("async.s_vpos", s_vpos, 0);
      chk("async.s_hpos", s_hpos, 0);
      chk("async.s_fc", s_frame_count, 0);
      chk("async.hpos", hpos, 0);
      chk("async.vpos", vpos, 0);
      step(1);
      rst_n = 1'b1;
      en = 1'b1;
      for (int c = 1; c <= 140; c++) begin
         step(1);
         e = (c + 1) / 2;
         h = e % 7;
         v = (e / 7) % 5;
         chk("tog.hpos", s_hpos, h);
         chk("tog.vpos", s_vpos, v);
         chk("tog.hsync", s_hsync, h != 5);
         chk("tog.vsync", s_vsync, v != 3);
         chk("tog.disp", s_display_on, h < 4 && v < 2);
         chk("tog.ls", s_line_start, (c % 2 == 1) && h == 0);
         chk("tog.fs", s_frame_start, (c % 2 == 1) && h == 0 && v == 0);
         chk("tog.fc", s_frame_count, e / 35);
         en = ~en;
      end
      step(35769);
      chk("pre_wrap.hpos", s_hpos, 6);
      chk("pre_wrap.vpos", s_vpos, 4);
      chk("pre_wrap.fc", s_frame_count, 1023);
      chk("pre_wrap.fs", s_frame_start, 0);
      step(1);
      chk("fc_wrap.hpos", s_hpos, 0);
      chk("fc_wrap.vpos", s_vpos, 0);
      chk("fc_wrap.fs", s_frame_start, 1);
      chk("fc_wrap.ls", s_line_start, 1);
      chk("fc_wrap.fc", s_frame_count, 0);
      step(1);
      chk("post_wrap.fs", s_frame_start, 0);
      chk("post_wrap.ls", s_line_start, 0);
      chk("post_wrap.hpos", s_hpos, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
